// File: rtl/obi_mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory OBI signals around obi_mem_arbiter.
// slave: the arbiter's view; master: the core and memory side driving it.
interface obi_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Instruction-fetch port
    logic                      instr_req_i;
    logic                      instr_gnt_o;
    logic [ADDR_WIDTH-1:0]     instr_addr_i;
    logic                      instr_rvalid_o;
    logic [DATA_WIDTH-1:0]     instr_rdata_o;

    // Data-access port
    logic                      data_req_i;
    logic                      data_gnt_o;
    logic [ADDR_WIDTH-1:0]     data_addr_i;
    logic                      data_we_i;
    logic [DATA_WIDTH/8-1:0]   data_be_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic                      data_rvalid_o;
    logic [DATA_WIDTH-1:0]     data_rdata_o;

    // Shared memory port
    logic                      mem_req_o;
    logic [ADDR_WIDTH-1:0]     mem_addr_o;
    logic                      mem_we_o;
    logic [DATA_WIDTH/8-1:0]   mem_be_o;
    logic [DATA_WIDTH-1:0]     mem_wdata_o;
    logic                      mem_gnt_i;
    logic                      mem_rvalid_i;
    logic [DATA_WIDTH-1:0]     mem_rdata_i;

    // Status
    logic                      busy_o;
    logic                      err_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output busy_o, err_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  busy_o, err_o
    );
endinterface

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory port between instruction fetch and data access, routing responses in order.
// Define OBI_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority, DATA over INSTR.
module obi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    obi_mem_arbiter_if.slave  bus
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED_INSTR,
        ST_LOCKED_DATA
    } state_e;

    state_e              state_q;
    owner_e              sel;
    owner_e              contend_winner;
    logic                sel_req;
    logic                mem_req;
    logic                push;
    logic                pop;
    logic                stray;
    logic                fifo_empty;
    logic                fifo_full;
    owner_e              head;

    owner_e              fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                err_q;

    logic [ADDR_WIDTH-1:0] addr_mux;
    logic                  we_mux;
    logic [BE_WIDTH-1:0]   be_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;

    // ------------------------------------------------------------------
    // Contention winner
    // ------------------------------------------------------------------
`ifdef OBI_ARB_ROUND_ROBIN_EN
    owner_e last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= OWNER_INSTR;
        end else if (push) begin
            last_q <= sel;
        end
    end

    assign contend_winner = (last_q == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
`else
    assign contend_winner = OWNER_DATA;
`endif

    // ------------------------------------------------------------------
    // Requester selection: a locked owner holds the bus until granted
    // ------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel = OWNER_DATA;
        unique case (state_q)
            ST_LOCKED_INSTR: sel = OWNER_INSTR;
            ST_LOCKED_DATA:  sel = OWNER_DATA;
            default: begin
                if (bus.data_req_i && bus.instr_req_i) begin
                    sel = contend_winner;
                end else if (bus.instr_req_i) begin
                    sel = OWNER_INSTR;
                end else begin
                    sel = OWNER_DATA;
                end
            end
        endcase
    end

    assign sel_req    = (sel == OWNER_DATA) ? bus.data_req_i : bus.instr_req_i;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == MAX_CNT);
    assign mem_req    = sel_req && !fifo_full && !rst_i;

    assign push  = mem_req && bus.mem_gnt_i;
    assign pop   = bus.mem_rvalid_i && !fifo_empty;
    assign stray = bus.mem_rvalid_i && fifo_empty;

    // ------------------------------------------------------------------
    // Address-phase mux; fetches are always full-word reads
    // ------------------------------------------------------------------
    always_comb begin
        addr_mux  = bus.instr_addr_i;
        we_mux    = 1'b0;
        be_mux    = '1;
        wdata_mux = '0;
        if (sel == OWNER_DATA) begin
            addr_mux  = bus.data_addr_i;
            we_mux    = bus.data_we_i;
            be_mux    = bus.data_be_i;
            wdata_mux = bus.data_wdata_i;
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_addr_o  = addr_mux;
    assign bus.mem_we_o    = we_mux;
    assign bus.mem_be_o    = be_mux;
    assign bus.mem_wdata_o = wdata_mux;

    assign bus.instr_gnt_o = push && (sel == OWNER_INSTR);
    assign bus.data_gnt_o  = push && (sel == OWNER_DATA);

    // ------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mem_req && !bus.mem_gnt_i) begin
                        state_q <= (sel == OWNER_DATA) ? ST_LOCKED_DATA : ST_LOCKED_INSTR;
                    end
                end
                ST_LOCKED_INSTR,
                ST_LOCKED_DATA: begin
                    if (bus.mem_gnt_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // In-order ID FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= sel;
        end
    end

    assign head = fifo_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (stray) begin
            err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Response routing and status
    // ------------------------------------------------------------------
    assign bus.instr_rvalid_o = pop && (head == OWNER_INSTR);
    assign bus.data_rvalid_o  = pop && (head == OWNER_DATA);
    assign bus.instr_rdata_o  = bus.mem_rdata_i;
    assign bus.data_rdata_o   = bus.mem_rdata_i;

    assign bus.busy_o = (count_q != '0) || mem_req;
    assign bus.err_o  = err_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter (MAX_OUTSTANDING = 2).
// Expectations follow OBI_ARB_ROUND_ROBIN_EN when the macro is defined.
module tb_obi_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    obi_mem_arbiter #(
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = '0;
        bus.data_req_i   = 1'b0;
        bus.data_addr_i  = '0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = '0;
        bus.data_wdata_i = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.instr_req_i = 1'b1;
        bus.mem_gnt_i   = 1'b1;
        #2;
        n_total++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bus.mem_req_o); else n_pass++;
        n_total++; if (bus.instr_gnt_o !== 1'b0) $display("FAIL reset_instr_gnt: got %b want 0", bus.instr_gnt_o); else n_pass++;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else n_pass++;
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_o); else n_pass++;
        tick();
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0220_0000;
        bus.mem_gnt_i    = 1'b1;
        #2;
        n_total++; if (bus.instr_gnt_o !== 1'b1) $display("FAIL fetch_gnt: got %b want 1", bus.instr_gnt_o); else n_pass++;
        n_total++; if (bus.mem_addr_o !== 32'h0220_0000) $display("FAIL fetch_addr: got %h want 02200000", bus.mem_addr_o); else n_pass++;
        n_total++; if (bus.mem_be_o !== 4'hF || bus.mem_we_o !== 1'b0) $display("FAIL fetch_be_we: got be=%h we=%b want be=f we=0", bus.mem_be_o, bus.mem_we_o); else n_pass++;
        n_total++; if (bus.data_rvalid_o !== 1'b0) $display("FAIL fetch_data_rvalid_c0: got %b want 0", bus.data_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0013;
        #2;
        n_total++; if (bus.instr_rvalid_o !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", bus.instr_rvalid_o); else n_pass++;
        n_total++; if (bus.instr_rdata_o !== 32'h0000_0013) $display("FAIL fetch_rdata: got %h want 00000013", bus.instr_rdata_o); else n_pass++;
        n_total++; if (bus.data_rvalid_o !== 1'b0) $display("FAIL fetch_data_rvalid_c1: got %b want 0", bus.data_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        #2;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL fetch_busy_after: got %b want 0", bus.busy_o); else n_pass++;
        tick();
    endtask

    task automatic test_contention();
        // 1 = DATA wins that cycle
`ifdef OBI_ARB_ROUND_ROBIN_EN
        logic [3:0] exp_data = 4'b0101;  // bit i for cycle i: D, I, D, I
`else
        logic [3:0] exp_data = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            bus.instr_req_i  = 1'b1;
            bus.instr_addr_i = 32'h0000_1000;
            bus.data_req_i   = 1'b1;
            bus.data_addr_i  = 32'h0000_2000;
            bus.data_be_i    = 4'h3;
            bus.mem_gnt_i    = 1'b1;
            bus.mem_rvalid_i = (i > 0);
            #2;
            n_total++; if (bus.data_gnt_o !== exp_data[i] || bus.instr_gnt_o !== !exp_data[i])
                $display("FAIL contend_gnt[%0d]: got d=%b i=%b want d=%b i=%b", i, bus.data_gnt_o, bus.instr_gnt_o, exp_data[i], !exp_data[i]);
            else n_pass++;
            if (i > 0) begin
                n_total++; if (bus.data_rvalid_o !== exp_data[i-1] || bus.instr_rvalid_o !== !exp_data[i-1])
                    $display("FAIL contend_rvalid[%0d]: got d=%b i=%b want d=%b i=%b", i, bus.data_rvalid_o, bus.instr_rvalid_o, exp_data[i-1], !exp_data[i-1]);
                else n_pass++;
            end
            tick();
        end
        // DATA drops out: INSTR gets the next cycle, last DATA/INSTR response drains
        bus.data_req_i   = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.instr_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_1000) $display("FAIL contend_instr_next: got gnt=%b addr=%h want 1 00001000", bus.instr_gnt_o, bus.mem_addr_o); else n_pass++;
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.instr_rvalid_o !== 1'b1) $display("FAIL contend_last_rvalid: got %b want 1", bus.instr_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_stall_lock();
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = 32'h0000_0A00;
        bus.data_addr_i  = 32'h0000_0B00;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_total++; if (bus.mem_addr_o !== 32'h0000_0A00 || bus.instr_gnt_o !== 1'b0) $display("FAIL stall_hold[%0d]: got addr=%h gnt=%b want 00000a00 0", i, bus.mem_addr_o, bus.instr_gnt_o); else n_pass++;
            tick();
        end
        bus.data_req_i = 1'b1;
        #2;
        n_total++; if (bus.mem_addr_o !== 32'h0000_0A00 || bus.data_gnt_o !== 1'b0) $display("FAIL stall_locked: got addr=%h dgnt=%b want 00000a00 0", bus.mem_addr_o, bus.data_gnt_o); else n_pass++;
        tick();
        bus.mem_gnt_i = 1'b1;
        #2;
        n_total++; if (bus.instr_gnt_o !== 1'b1 || bus.data_gnt_o !== 1'b0) $display("FAIL stall_release: got i=%b d=%b want 1 0", bus.instr_gnt_o, bus.data_gnt_o); else n_pass++;
        tick();
        bus.instr_req_i  = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.data_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_0B00) $display("FAIL stall_data_after: got gnt=%b addr=%h want 1 00000b00", bus.data_gnt_o, bus.mem_addr_o); else n_pass++;
        n_total++; if (bus.instr_rvalid_o !== 1'b1) $display("FAIL stall_instr_rsp: got %b want 1", bus.instr_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.data_rvalid_o !== 1'b1) $display("FAIL stall_data_rsp: got %b want 1", bus.data_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_fifo_full();
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0000_3000;
        bus.instr_addr_i = 32'h0000_4000;
        bus.mem_gnt_i    = 1'b1;
        tick();
        bus.data_req_i  = 1'b0;
        bus.instr_req_i = 1'b1;
        tick();
        bus.data_req_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_total++; if (bus.mem_req_o !== 1'b0 || bus.data_gnt_o !== 1'b0 || bus.instr_gnt_o !== 1'b0)
                $display("FAIL full_blocked[%0d]: got req=%b d=%b i=%b want 0 0 0", i, bus.mem_req_o, bus.data_gnt_o, bus.instr_gnt_o);
            else n_pass++;
            n_total++; if (bus.busy_o !== 1'b1) $display("FAIL full_busy[%0d]: got %b want 1", i, bus.busy_o); else n_pass++;
            tick();
        end
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_000D;
        #2;
        n_total++; if (bus.data_rvalid_o !== 1'b1 || bus.instr_rvalid_o !== 1'b0 || bus.data_rdata_o !== 32'h0000_000D)
            $display("FAIL full_first_rsp: got d=%b i=%b rdata=%h want 1 0 0000000d", bus.data_rvalid_o, bus.instr_rvalid_o, bus.data_rdata_o);
        else n_pass++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        #2;
        n_total++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h0000_3000) $display("FAIL full_reassert: got req=%b addr=%h want 1 00003000", bus.mem_req_o, bus.mem_addr_o); else n_pass++;
        tick();
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h0000_0001;
        #2;
        n_total++; if (bus.instr_rvalid_o !== 1'b1 || bus.data_rvalid_o !== 1'b0) $display("FAIL full_second_rsp: got i=%b d=%b want 1 0", bus.instr_rvalid_o, bus.data_rvalid_o); else n_pass++;
        n_total++; if (bus.data_gnt_o !== 1'b1) $display("FAIL full_data_gnt: got %b want 1", bus.data_gnt_o); else n_pass++;
        tick();
        idle_inputs();
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.data_rvalid_o !== 1'b1) $display("FAIL full_third_rsp: got %b want 1", bus.data_rvalid_o); else n_pass++;
        tick();
        idle_inputs();
        #2;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL full_drained_busy: got %b want 0", bus.busy_o); else n_pass++;
        tick();
    endtask

    task automatic test_stray();
        n_total++; if (bus.err_o !== 1'b0) $display("FAIL stray_err_before: got %b want 0", bus.err_o); else n_pass++;
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) $display("FAIL stray_rvalid: got i=%b d=%b want 0 0", bus.instr_rvalid_o, bus.data_rvalid_o); else n_pass++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        #2;
        n_total++; if (bus.err_o !== 1'b1) $display("FAIL stray_err_set: got %b want 1", bus.err_o); else n_pass++;
        tick();
        tick();
        tick();
        n_total++; if (bus.err_o !== 1'b1) $display("FAIL stray_err_sticky: got %b want 1", bus.err_o); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bus.data_req_i   = 1'b1;
        bus.data_addr_i  = 32'h0000_5000;
        bus.instr_addr_i = 32'h0000_6000;
        bus.mem_gnt_i    = 1'b1;
        tick();
        bus.data_req_i  = 1'b0;
        bus.instr_req_i = 1'b1;
        tick();
        bus.data_req_i   = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (bus.mem_req_o !== 1'b0 || bus.data_gnt_o !== 1'b0 || bus.instr_gnt_o !== 1'b0)
            $display("FAIL midrst_req_gnt: got req=%b d=%b i=%b want 0 0 0", bus.mem_req_o, bus.data_gnt_o, bus.instr_gnt_o);
        else n_pass++;
        n_total++; if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) $display("FAIL midrst_rvalid: got i=%b d=%b want 0 0", bus.instr_rvalid_o, bus.data_rvalid_o); else n_pass++;
        n_total++; if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) $display("FAIL midrst_busy_err: got busy=%b err=%b want 0 0", bus.busy_o, bus.err_o); else n_pass++;
        tick();
        idle_inputs();
        rst = 1'b0;
        #2;
        n_total++; if (bus.busy_o !== 1'b0) $display("FAIL midrst_busy_after: got %b want 0", bus.busy_o); else n_pass++;
        tick();
        bus.mem_rvalid_i = 1'b1;
        #2;
        n_total++; if (bus.instr_rvalid_o !== 1'b0 || bus.data_rvalid_o !== 1'b0) $display("FAIL midrst_late_rvalid: got i=%b d=%b want 0 0", bus.instr_rvalid_o, bus.data_rvalid_o); else n_pass++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        #2;
        n_total++; if (bus.err_o !== 1'b1) $display("FAIL midrst_late_err: got %b want 1", bus.err_o); else n_pass++;
        tick();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        idle_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_stall_lock();
        test_fifo_full();
        test_stray();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
